// File: rtl/trisc_control_sequencer.sv
// TRISC control sequencer: latches the instruction word, decodes the 11-opcode set to a
// registered one-hot vector and sequences fetch/load/decode/execute with Moore strobes.
module trisc_control_sequencer #(
  parameter int OP_W   = 4,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [OP_W+ADDR_W-1:0] instr_in,
  input  logic                   acc_zero,
  input  logic                   acc_neg,
  output logic                   mem_rd,
  output logic                   mem_wr,
  output logic                   addr_sel,
  output logic                   ir_ld,
  output logic                   pc_inc,
  output logic                   pc_ld,
  output logic                   acc_ld,
  output logic [2:0]             alu_op,
  output logic [ADDR_W-1:0]      operand,
  output logic [10:0]            op_onehot,
  output logic                   halted,
  output logic                   illegal,
  output logic [CNT_W-1:0]       instr_cnt,
  output logic [2:0]             fsm_state
);

  localparam int INSTR_W = OP_W + ADDR_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_LOAD   = 3'd2;
  localparam logic [2:0] S_DECODE = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_EXEC2  = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;
  localparam logic [2:0] S_TRAP   = 3'd7;

  // One-hot bit positions, LDA in the MSB.
  localparam int OH_LDA = 10;
  localparam int OH_STA = 9;
  localparam int OH_ADD = 8;
  localparam int OH_SUB = 7;
  localparam int OH_XOR = 6;
  localparam int OH_INC = 5;
  localparam int OH_CLR = 4;
  localparam int OH_JMP = 3;
  localparam int OH_JPZ = 2;
  localparam int OH_JPN = 1;
  localparam int OH_HLT = 0;

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [INSTR_W-1:0] ir;
  logic [OP_W-1:0]    ir_op;
  logic [10:0]        dec_onehot;
  logic               two_phase;
  logic               retire;

  assign ir_op     = ir[INSTR_W-1 -: OP_W];
  assign operand   = ir[ADDR_W-1:0];
  assign fsm_state = state;
  assign halted    = (state == S_HALT);

  // Any set bit above the 4-bit code makes the opcode illegal (all-zero one-hot).
  always_comb begin
    dec_onehot = '0;
    if ((ir_op >> 4) == '0) begin
      case (ir_op[3:0])
        4'b0000: dec_onehot[OH_LDA] = 1'b1;
        4'b0001: dec_onehot[OH_STA] = 1'b1;
        4'b0010: dec_onehot[OH_ADD] = 1'b1;
        4'b0011: dec_onehot[OH_SUB] = 1'b1;
        4'b0100: dec_onehot[OH_XOR] = 1'b1;
        4'b0110: dec_onehot[OH_INC] = 1'b1;
        4'b0111: dec_onehot[OH_CLR] = 1'b1;
        4'b1000: dec_onehot[OH_JMP] = 1'b1;
        4'b1100: dec_onehot[OH_JPZ] = 1'b1;
        4'b1001: dec_onehot[OH_JPN] = 1'b1;
        4'b1111: dec_onehot[OH_HLT] = 1'b1;
        default: dec_onehot = '0;
      endcase
    end
  end

  // Memory-operand ALU ops need a second execute cycle for the read data.
  assign two_phase = op_onehot[OH_LDA] | op_onehot[OH_ADD] |
                     op_onehot[OH_SUB] | op_onehot[OH_XOR];

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_LOAD;
      S_LOAD:   state_nxt = S_DECODE;
      S_DECODE: begin
        if (dec_onehot == '0)          state_nxt = S_TRAP;
        else if (dec_onehot[OH_HLT])   state_nxt = S_HALT;
        else                           state_nxt = S_EXEC;
      end
      S_EXEC:   state_nxt = two_phase ? S_EXEC2 : S_FETCH;
      S_EXEC2:  state_nxt = S_FETCH;
      S_HALT:   if (start) state_nxt = S_FETCH;
      S_TRAP:   state_nxt = S_TRAP;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign retire = ((state == S_EXEC) && !two_phase) ||
                  (state == S_EXEC2) ||
                  ((state == S_DECODE) && dec_onehot[OH_HLT]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ir        <= '0;
      op_onehot <= '0;
      instr_cnt <= '0;
      illegal   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_LOAD) ir <= instr_in;
      if (state == S_DECODE) begin
        op_onehot <= dec_onehot;
        if (dec_onehot == '0) illegal <= 1'b1;
      end
      if (retire && (instr_cnt != '1)) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    addr_sel = 1'b0;
    ir_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_ld    = 1'b0;
    acc_ld   = 1'b0;
    alu_op   = 3'b000;
    case (state)
      S_FETCH: mem_rd = 1'b1;
      S_LOAD: begin
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      S_EXEC: begin
        if (two_phase) begin
          mem_rd   = 1'b1;
          addr_sel = 1'b1;
        end
        if (op_onehot[OH_STA]) begin
          mem_wr   = 1'b1;
          addr_sel = 1'b1;
        end
        if (op_onehot[OH_INC]) begin
          acc_ld = 1'b1;
          alu_op = 3'b100;
        end
        if (op_onehot[OH_CLR]) begin
          acc_ld = 1'b1;
          alu_op = 3'b101;
        end
        pc_ld = op_onehot[OH_JMP] |
                (op_onehot[OH_JPZ] & acc_zero) |
                (op_onehot[OH_JPN] & acc_neg);
      end
      S_EXEC2: begin
        acc_ld = 1'b1;
        if (op_onehot[OH_ADD])      alu_op = 3'b001;
        else if (op_onehot[OH_SUB]) alu_op = 3'b010;
        else if (op_onehot[OH_XOR]) alu_op = 3'b011;
        else                        alu_op = 3'b000;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trisc_control_sequencer.sv
// Directed bench for trisc_control_sequencer: a default instance (OP_W=4, CNT_W=8) and a
// wide/saturating instance (OP_W=5, CNT_W=2) driven from one sequence of vectors.
module tb_trisc_control_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_HALT = 3'd6;
  localparam logic [2:0] ST_TRAP = 3'd7;

  // Strobe vector {mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, acc_ld, alu_op[2:0]}.
  localparam logic [9:0] SB_NONE  = 10'b0_0_0_0_0_0_0_000;
  localparam logic [9:0] SB_FETCH = 10'b1_0_0_0_0_0_0_000;
  localparam logic [9:0] SB_LOAD  = 10'b0_0_0_1_1_0_0_000;
  localparam logic [9:0] SB_MRD   = 10'b1_0_1_0_0_0_0_000;
  localparam logic [9:0] SB_STA   = 10'b0_1_1_0_0_0_0_000;
  localparam logic [9:0] SB_LDA2  = 10'b0_0_0_0_0_0_1_000;
  localparam logic [9:0] SB_ADD2  = 10'b0_0_0_0_0_0_1_001;
  localparam logic [9:0] SB_INC   = 10'b0_0_0_0_0_0_1_100;
  localparam logic [9:0] SB_CLR   = 10'b0_0_0_0_0_0_1_101;
  localparam logic [9:0] SB_PCLD  = 10'b0_0_0_0_0_1_0_000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // default instance
  logic       reset, start, acc_zero, acc_neg;
  logic [7:0] instr_in;
  logic       mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, acc_ld;
  logic [2:0] alu_op;
  logic [3:0] operand;
  logic [10:0] op_onehot;
  logic       halted, illegal;
  logic [7:0] instr_cnt;
  logic [2:0] fsm_state;
  logic [9:0] strb;
  assign strb = {mem_rd, mem_wr, addr_sel, ir_ld, pc_inc, pc_ld, acc_ld, alu_op};

  // wide-opcode, 2-bit counter instance
  logic       reset_b, start_b, acc_zero_b, acc_neg_b;
  logic [8:0] instr_b;
  logic       mem_rd_b, mem_wr_b, addr_sel_b, ir_ld_b, pc_inc_b, pc_ld_b, acc_ld_b;
  logic [2:0] alu_op_b;
  logic [3:0] operand_b;
  logic [10:0] op_onehot_b;
  logic       halted_b, illegal_b;
  logic [1:0] instr_cnt_b;
  logic [2:0] fsm_state_b;

  trisc_control_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
    .acc_zero(acc_zero), .acc_neg(acc_neg),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel), .ir_ld(ir_ld),
    .pc_inc(pc_inc), .pc_ld(pc_ld), .acc_ld(acc_ld), .alu_op(alu_op),
    .operand(operand), .op_onehot(op_onehot), .halted(halted), .illegal(illegal),
    .instr_cnt(instr_cnt), .fsm_state(fsm_state)
  );

  trisc_control_sequencer #(.OP_W(5), .ADDR_W(4), .CNT_W(2)) u_alt (
    .clk(clk), .reset(reset_b), .start(start_b), .instr_in(instr_b),
    .acc_zero(acc_zero_b), .acc_neg(acc_neg_b),
    .mem_rd(mem_rd_b), .mem_wr(mem_wr_b), .addr_sel(addr_sel_b), .ir_ld(ir_ld_b),
    .pc_inc(pc_inc_b), .pc_ld(pc_ld_b), .acc_ld(acc_ld_b), .alu_op(alu_op_b),
    .operand(operand_b), .op_onehot(op_onehot_b), .halted(halted_b), .illegal(illegal_b),
    .instr_cnt(instr_cnt_b), .fsm_state(fsm_state_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: present the instruction, then step through LOAD and DECODE into the next state.
  task automatic run_decode(input bit alt, input logic [8:0] instr);
    if (alt) instr_b = instr;
    else     instr_in = instr[7:0];
    tick();
    if (!alt) check("load_strobes", 32'(strb), 32'(SB_LOAD));
    tick();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; acc_zero = 1'b0; acc_neg = 1'b0; instr_in = '0;
    reset_b = 1'b1; start_b = 1'b0; acc_zero_b = 1'b0; acc_neg_b = 1'b0; instr_b = '0;
    #12;
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_strobes", 32'(strb), 32'(SB_NONE));
    check("rst_onehot", 32'(op_onehot), 32'd0);
    check("rst_cnt", 32'(instr_cnt), 32'd0);
    check("rst_flags", {30'd0, halted, illegal}, 32'd0);

    // LDA 5
    @(negedge clk);
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("lda_fetch", 32'(strb), 32'(SB_FETCH));
    run_decode(1'b0, 9'h005);
    check("lda_onehot", 32'(op_onehot), 32'h400);
    check("lda_exec", 32'(strb), 32'(SB_MRD));
    check("lda_operand", 32'(operand), 32'd5);
    tick();
    check("lda_exec2", 32'(strb), 32'(SB_LDA2));
    check("lda_cnt_pre", 32'(instr_cnt), 32'd0);
    tick();
    check("lda_cnt", 32'(instr_cnt), 32'd1);
    check("lda_refetch", 32'(strb), 32'(SB_FETCH));

    // JPZ 9 taken, JPZ 9 not taken, JPN 3 taken
    acc_zero = 1'b1;
    run_decode(1'b0, 9'h0C9);
    check("jpz_onehot", 32'(op_onehot), 32'h004);
    check("jpz_taken", 32'(strb), 32'(SB_PCLD));
    check("jpz_operand", 32'(operand), 32'd9);
    tick();
    acc_zero = 1'b0;
    run_decode(1'b0, 9'h0C9);
    check("jpz_not_taken", 32'(strb), 32'(SB_NONE));
    tick();
    acc_neg = 1'b1;
    run_decode(1'b0, 9'h093);
    check("jpn_onehot", 32'(op_onehot), 32'h002);
    check("jpn_taken", 32'(strb), 32'(SB_PCLD));
    tick();
    acc_neg = 1'b0;
    check("jump_cnt", 32'(instr_cnt), 32'd4);

    // STA 7, reset mid-EXEC
    run_decode(1'b0, 9'h017);
    check("sta_exec", 32'(strb), 32'(SB_STA));
    #2;
    reset = 1'b1;
    #1;
    check("sta_rst_strobes", 32'(strb), 32'(SB_NONE));
    check("sta_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("sta_rst_cnt", 32'(instr_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    check("post_rst_fetch", 32'(strb), 32'(SB_FETCH));

    // HLT, hold, resume
    run_decode(1'b0, 9'h0F0);
    check("hlt_halted", 32'(halted), 32'd1);
    check("hlt_onehot", 32'(op_onehot), 32'h001);
    check("hlt_cnt", 32'(instr_cnt), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hlt_hold", 32'(fsm_state), 32'(ST_HALT));
    end
    check("hlt_strobes", 32'(strb), 32'(SB_NONE));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_state", 32'(fsm_state), 32'(ST_FETCH));
    check("resume_halted", 32'(halted), 32'd0);

    // INC, ADD 10, CLR
    run_decode(1'b0, 9'h060);
    check("inc_exec", 32'(strb), 32'(SB_INC));
    tick();
    run_decode(1'b0, 9'h02A);
    check("add_onehot", 32'(op_onehot), 32'h100);
    check("add_exec", 32'(strb), 32'(SB_MRD));
    tick();
    check("add_exec2", 32'(strb), 32'(SB_ADD2));
    tick();
    run_decode(1'b0, 9'h070);
    check("clr_exec", 32'(strb), 32'(SB_CLR));
    tick();
    check("alu_cnt", 32'(instr_cnt), 32'd4);

    // Illegal opcode 0101
    run_decode(1'b0, 9'h050);
    check("ill_state", 32'(fsm_state), 32'(ST_TRAP));
    check("ill_onehot", 32'(op_onehot), 32'd0);
    check("ill_flag", 32'(illegal), 32'd1);
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("trap_strobes", 32'(strb), 32'(SB_NONE));
    end
    start = 1'b0;
    check("trap_held", 32'(fsm_state), 32'(ST_TRAP));
    check("trap_cnt", 32'(instr_cnt), 32'd4);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ill_cleared", 32'(illegal), 32'd0);
    reset = 1'b0;

    // OP_W=5, CNT_W=2: counter saturation then wide illegal opcode
    @(negedge clk);
    reset_b = 1'b0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      run_decode(1'b1, 9'b0_0110_0001);
      tick();
      check("sat_cnt", 32'(instr_cnt_b), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    run_decode(1'b1, 9'b1_0000_0000);
    check("wide_ill_state", 32'(fsm_state_b), 32'(ST_TRAP));
    check("wide_ill_flag", 32'(illegal_b), 32'd1);
    check("wide_ill_onehot", 32'(op_onehot_b), 32'd0);
    check("wide_ill_cnt", 32'(instr_cnt_b), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trisc_control_sequencer.md
Name: trisc_control_sequencer

Overview:
- Parametrised successor to the TRISC 4-to-11 opcode decoder.
- Latches the instruction word and decodes the 11-opcode set into a registered one-hot vector.
- Sequences fetch/decode/execute through an FSM and drives datapath and memory strobes.
- Adds start/halt/illegal-opcode handling and a retired-instruction counter, none of which the combinational decoder had.

Parameters:
- OP_W, 4: opcode field width; must be >= 4.
- ADDR_W, 4: operand/address field width; instruction width is OP_W+ADDR_W.
- CNT_W, 8: width of the retired-instruction counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-high reset.
- start  input  1  level; leaves IDLE or HALT when high.
- instr_in  input  OP_W+ADDR_W  memory read data; the opcode is in the MSBs.
- acc_zero  input  1  accumulator == 0 flag.
- acc_neg  input  1  accumulator MSB flag.
- mem_rd  output  1  memory read strobe; data is valid on instr_in one cycle later.
- mem_wr  output  1  memory write strobe (STA).
- addr_sel  output  1  0 = memory address from PC, 1 = from operand.
- ir_ld  output  1  instruction register load.
- pc_inc  output  1  PC increment.
- pc_ld  output  1  PC load from operand (taken jump).
- acc_ld  output  1  accumulator load.
- alu_op  output  3  000 pass, 001 add, 010 sub, 011 xor, 100 inc, 101 clr.
- operand  output  ADDR_W  latched operand field.
- op_onehot  output  11  registered {LDA,STA,ADD,SUB,XOR,INC,CLR,JMP,JPZ,JPN,HLT}, LDA is the MSB.
- halted  output  1  FSM is in HALT.
- illegal  output  1  sticky illegal-opcode flag.
- instr_cnt  output  CNT_W  count of retired instructions, saturating.

Behaviour:
- Reset, asynchronous and effective immediately:
  - FSM goes to IDLE.
  - IR, operand, op_onehot, instr_cnt, illegal and halted are cleared to 0.
  - All strobes are 0 and alu_op = 000.
- All strobes are Moore outputs decoded from state and the registered opcode. No strobe is asserted in IDLE, HALT or TRAP.
- Opcode map, applied to the low 4 bits of the opcode field:
  - LDA 0000, STA 0001, ADD 0010, SUB 0011, XOR 0100, INC 0110, CLR 0111.
  - JMP 1000, JPZ 1100, JPN 1001, HLT 1111.
  - Codes 0101, 1010, 1011, 1101 and 1110 are illegal.
  - When OP_W > 4, any nonzero upper opcode bit makes the opcode illegal.
- FSM states and transitions:
  - IDLE: waits for start = 1, then goes to FETCH.
  - FETCH: mem_rd = 1, addr_sel = 0. Next state is LOAD.
  - LOAD: ir_ld = 1, pc_inc = 1. IR captures instr_in; operand is updated on the same edge. Next state is DECODE.
  - DECODE: op_onehot is updated from IR and is all-zero for an illegal code. Next state is EXEC for a legal non-HLT opcode, HALT for HLT, and TRAP for an illegal code; TRAP also sets illegal = 1.
  - EXEC, by opcode:
    - LDA/ADD/SUB/XOR: mem_rd = 1, addr_sel = 1, then go to EXEC2.
    - STA: mem_wr = 1, addr_sel = 1.
    - INC: acc_ld = 1, alu_op = 100.
    - CLR: acc_ld = 1, alu_op = 101.
    - JMP: pc_ld = 1.
    - JPZ: pc_ld = acc_zero.
    - JPN: pc_ld = acc_neg.
    - All opcodes other than LDA/ADD/SUB/XOR then go to FETCH.
  - EXEC2: acc_ld = 1, with alu_op = 000/001/010/011 for LDA/ADD/SUB/XOR. Next state is FETCH.
  - HALT: halted = 1. Goes to FETCH when start = 1, resuming at the current PC. HLT does not increment the PC beyond the increment in LOAD.
  - TRAP: stays there until reset; start is ignored.
- Flags for JPZ/JPN are sampled in the EXEC cycle only.
- Cycle counts from FETCH to the next FETCH:
  - 4 cycles for STA, INC, CLR and the jumps.
  - 5 cycles for LDA, ADD, SUB and XOR.
- instr_cnt:
  - Increments by 1 on the final cycle of each legal instruction: the EXEC or EXEC2 edge that returns to FETCH, and the DECODE edge into HALT.
  - Saturates at 2^CNT_W-1 with no wrap.
  - Illegal opcodes are not counted.
- op_onehot holds its value from DECODE until the next DECODE, and is at most one-hot.
- Reset mid-instruction abandons the instruction with no partial strobe. The FSM returns to IDLE on the reset edge and the counter is cleared.

Test Plan:
- Reset, then start = 1; instr_in = 0000_0101 (LDA 5):
  - FETCH gives mem_rd with addr_sel = 0.
  - LOAD gives ir_ld and pc_inc.
  - DECODE gives op_onehot = 100_0000_0000.
  - EXEC gives mem_rd with addr_sel = 1 and operand = 5.
  - EXEC2 gives acc_ld with alu_op = 000.
  - instr_cnt = 1.
- Jump conditions:
  - JPZ 9 with acc_zero = 1: pc_ld = 1 in EXEC. Repeat with acc_zero = 0: pc_ld = 0.
  - JPN 3 with acc_neg = 1: pc_ld = 1 in EXEC.
- Halt and resume:
  - Instruction 1111_0000: halted = 1 from the cycle after DECODE, and instr_cnt increments.
  - Hold start = 0 for 10 cycles: the FSM stays in HALT.
  - Pulse start = 1: the next state is FETCH with halted = 0.
- Illegal opcode:
  - Opcode 0101: op_onehot = 0, illegal = 1, TRAP is held, no strobes are asserted, start is ignored and instr_cnt is unchanged.
  - Reset clears illegal.
- Saturation and parameterisation:
  - With CNT_W = 2, execute 5 INC instructions: instr_cnt = 1, 2, 3, 3, 3.
  - With OP_W = 5, opcode 1_0000 traps as illegal.
- Asynchronous reset asserted mid-EXEC of STA:
  - mem_wr drops immediately, the FSM goes to IDLE and instr_cnt = 0.
  - After start, the next FETCH occurs normally.
